// File: rtl/rice_partition_sequencer_pkg.sv
// Shared definitions for the Rice partition sequencer: FSM encoding,
// datapath widths and the Rice parameter ceiling.
package rice_partition_sequencer_pkg;

    localparam int RICE_PARAM_W = 4;
    localparam int RESID_W      = 16;
    localparam int COUNT_W      = 16;

    // Largest Rice parameter the bitstream writer accepts (15 is the escape code).
    localparam logic [RICE_PARAM_W-1:0] RICE_PARAM_MAX = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } seq_state_t;

    // Saturate an optimizer result into the legal Rice parameter range.
    function automatic logic [RICE_PARAM_W-1:0] clamp_param(input logic [RICE_PARAM_W-1:0] best);
        return (best > RICE_PARAM_MAX) ? RICE_PARAM_MAX : best;
    endfunction

endpackage

// File: rtl/rice_seq_counter.sv
// Loadable down-counter with a zero flag. Used for the per-partition
// sample budget and, when enabled, for the optimizer watchdog.
module rice_seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rice_partition_sequencer.sv
// Rice partition sequencer: splits one FLAC residual block into
// 2^PARTITION_ORDER partitions, clears and feeds the shared Rice optimizer
// for each one, and hands each chosen parameter downstream on a
// valid/ready handshake.
// Optional feature macro: RICE_SEQ_WATCHDOG_EN -- bounds the wait for
// iOptDone to TIMEOUT cycles, then emits the escape-safe parameter 14
// and pulses oError.
module rice_partition_sequencer
    import rice_partition_sequencer_pkg::*;
#(
    parameter int BLOCK_SIZE      = 4096,
    parameter int PARTITION_ORDER = 2,
    parameter int TIMEOUT         = 64
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic [5:0]                iPredOrder,
    input  logic                      iValid,
    input  logic signed [RESID_W-1:0] iResidual,
    output logic                      oReady,
    output logic                      oOptReset,
    output logic                      oOptValid,
    output logic signed [RESID_W-1:0] oOptResidual,
    input  logic                      iOptDone,
    input  logic [RICE_PARAM_W-1:0]   iOptBest,
    output logic [RICE_PARAM_W-1:0]   oParam,
    output logic                      oParamValid,
    input  logic                      iParamReady,
    output logic [7:0]                oPartIndex,
    output logic                      oBlockDone,
    output logic                      oError
);

    localparam int PART_SIZE = BLOCK_SIZE >> PARTITION_ORDER;
    localparam int NPART     = 1 << PARTITION_ORDER;

    localparam logic [COUNT_W-1:0] PART_SIZE_W = COUNT_W'(PART_SIZE);
    localparam logic [COUNT_W-1:0] LAST_PART   = COUNT_W'(NPART - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [5:0]         pred_order;
    logic [COUNT_W-1:0] part_idx;
    logic [COUNT_W-1:0] samp_value;
    logic               samp_load;
    logic               samp_zero;
    logic               xfer;
    logic               start_ok;
    logic               start_bad;
    logic               accept;
    logic               last_part;
    logic               wd_fire;

    assign xfer      = iValid && oReady;
    assign last_part = (part_idx == LAST_PART);
    assign accept    = (state == ST_EMIT) && iParamReady;

    // The counter holds "samples left minus one", so the zero flag marks
    // the transfer that completes the partition without an extra cycle.
    assign samp_value = (part_idx == '0)
                      ? (PART_SIZE_W - {10'd0, pred_order} - COUNT_W'(1))
                      : (PART_SIZE_W - COUNT_W'(1));

    rice_seq_counter #(.W(COUNT_W)) u_samples (
        .clk   (iClock),
        .rst   (iReset),
        .load  (samp_load),
        .value (samp_value),
        .dec   (xfer),
        .zero  (samp_zero)
    );

`ifdef RICE_SEQ_WATCHDOG_EN
    logic wd_zero;

    // Rearmed in every state other than WAIT, counts down only while waiting.
    rice_seq_counter #(.W(COUNT_W)) u_watchdog (
        .clk   (iClock),
        .rst   (iReset),
        .load  (state != ST_WAIT),
        .value (COUNT_W'(TIMEOUT - 1)),
        .dec   (state == ST_WAIT),
        .zero  (wd_zero)
    );

    // A real result in the final cycle still wins over the timeout.
    assign wd_fire = (state == ST_WAIT) && !iOptDone && wd_zero;
`else
    assign wd_fire = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next  = state;
        oReady      = 1'b0;
        oOptReset   = 1'b0;
        oParamValid = 1'b0;
        samp_load   = 1'b0;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    if ({10'd0, iPredOrder} < PART_SIZE_W) begin
                        start_ok   = 1'b1;
                        state_next = ST_CLEAR;
                    end else begin
                        start_bad  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                oOptReset  = 1'b1;
                samp_load  = 1'b1;
                state_next = ST_FEED;
            end
            ST_FEED: begin
                oReady = 1'b1;
                if (iValid && samp_zero) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iOptDone || wd_fire) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                oParamValid = 1'b1;
                if (iParamReady) begin
                    state_next = last_part ? ST_IDLE : ST_CLEAR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath: optimizer feed, parameter capture, indices and pulses.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            pred_order   <= '0;
            part_idx     <= '0;
            oOptValid    <= 1'b0;
            oOptResidual <= '0;
            oParam       <= '0;
            oBlockDone   <= 1'b0;
            oError       <= 1'b0;
        end else begin
            oOptValid  <= xfer;
            oError     <= start_bad || wd_fire;
            oBlockDone <= accept && last_part;

            if (xfer) begin
                oOptResidual <= iResidual;
            end

            if (start_ok) begin
                pred_order <= iPredOrder;
                part_idx   <= '0;
            end else if (accept && !last_part) begin
                part_idx <= part_idx + COUNT_W'(1);
            end

            if (state == ST_WAIT) begin
                if (iOptDone) begin
                    oParam <= clamp_param(iOptBest);
                end else if (wd_fire) begin
                    oParam <= RICE_PARAM_MAX;
                end
            end
        end
    end

    assign oPartIndex = part_idx[7:0];

endmodule

// File: tb/tb_rice_partition_sequencer.sv
// Self-checking bench for rice_partition_sequencer (BLOCK_SIZE=16,
// PARTITION_ORDER=2, TIMEOUT=8). A table of block scenarios is run in a
// loop; a small optimizer model answers each partition, and scoreboards
// track forwarded samples and emitted parameters.
module tb_rice_partition_sequencer;

    localparam int BLOCK_SIZE = 16;
    localparam int PORDER     = 2;
    localparam int TIMEOUT    = 8;
    localparam int PART       = BLOCK_SIZE >> PORDER;
    localparam int NPART      = 1 << PORDER;
    localparam int HOLD       = 120;
    localparam int BUDGET     = 400;
`ifdef RICE_SEQ_WATCHDOG_EN
    localparam int WD_ERRORS  = 1;
    localparam int WD_WAIT    = TIMEOUT;
`else
    localparam int WD_ERRORS  = 0;
    localparam int WD_WAIT    = HOLD;
`endif

    typedef struct {
        logic [5:0] pred;
        logic [3:0] best;
        bit         gapped;
        int         stall;
        bit         restart;
        int         withhold;
        int         exp_len0;
        logic [3:0] exp_param;
        int         exp_resets;
        int         exp_params;
        int         exp_errors;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [3:0] param;
        logic [7:0] idx;
    } par_t;

    logic               iClock;
    logic               iReset;
    logic               iStart;
    logic [5:0]         iPredOrder;
    logic               iValid;
    logic signed [15:0] iResidual;
    logic               oReady;
    logic               oOptReset;
    logic               oOptValid;
    logic signed [15:0] oOptResidual;
    logic               iOptDone;
    logic [3:0]         iOptBest;
    logic [3:0]         oParam;
    logic               oParamValid;
    logic               iParamReady;
    logic [7:0]         oPartIndex;
    logic               oBlockDone;
    logic               oError;

    rice_partition_sequencer #(
        .BLOCK_SIZE      (BLOCK_SIZE),
        .PARTITION_ORDER (PORDER),
        .TIMEOUT         (TIMEOUT)
    ) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iStart       (iStart),
        .iPredOrder   (iPredOrder),
        .iValid       (iValid),
        .iResidual    (iResidual),
        .oReady       (oReady),
        .oOptReset    (oOptReset),
        .oOptValid    (oOptValid),
        .oOptResidual (oOptResidual),
        .iOptDone     (iOptDone),
        .iOptBest     (iOptBest),
        .oParam       (oParam),
        .oParamValid  (oParamValid),
        .iParamReady  (iParamReady),
        .oPartIndex   (oPartIndex),
        .oBlockDone   (oBlockDone),
        .oError       (oError)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    int errors = 0;
    int checks = 0;

    // Scoreboards and per-block bookkeeping.
    logic signed [15:0] samp_q[$];
    par_t               par_q[$];
    vec_t               vecs[8];

    logic [5:0] cur_pred;
    logic [3:0] cur_best;
    logic [3:0] cur_param;
    bit         cur_gapped;
    bit         start_req;
    bit         restart_pending;
    bit         feeding;
    bit         waiting;
    bit         bd_pending;
    int         stall_left;
    int         withhold_part;
    int         len0;
    int         exp_part;
    int         part_cnt;
    int         reset_cnt;
    int         param_cnt;
    int         err_cnt;
    int         done_cnt;
    int         wait_cnt;
    int         wait_total;
    int         samp_pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs.
    task automatic step_cycle();
        par_t e;
        @(negedge iClock);

        // Forwarded samples must appear exactly one cycle after their transfer.
        if (oOptValid) begin
            if (samp_q.size() == 0) begin
                check("opt_valid_spurious", 32'd1, 32'd0);
            end else begin
                check("opt_residual", oOptResidual, samp_q.pop_front());
                part_cnt++;
            end
        end
        if (samp_q.size() != 0) begin
            check("opt_valid_missing", samp_q.size(), 32'd0);
            samp_q.delete();
        end

        if (oError) err_cnt++;
        if (oBlockDone || bd_pending) check("block_done_pulse", oBlockDone, bd_pending);
        if (oBlockDone) done_cnt++;
        bd_pending = 1'b0;

        if (oOptReset) begin
            reset_cnt++;
            exp_part++;
            part_cnt = 0;
            feeding  = 1'b1;
        end

        // Optimizer model: answers once the sequencer stops taking samples.
        iOptDone = 1'b0;
        if (feeding && !oReady && !oOptReset && !oParamValid) begin
            feeding = 1'b0;
            check("part_len", part_cnt, (exp_part == 0) ? len0 : PART);
            if (exp_part == withhold_part) begin
                waiting  = 1'b1;
                wait_cnt = 1;
`ifdef RICE_SEQ_WATCHDOG_EN
                par_q.push_back('{4'd14, 8'(exp_part)});
`endif
            end else begin
                iOptDone = 1'b1;
                iOptBest = cur_best;
                par_q.push_back('{cur_param, 8'(exp_part)});
            end
        end else if (waiting) begin
            if (oParamValid) begin
                waiting    = 1'b0;
                wait_total = wait_cnt;
            end else begin
                wait_cnt++;
`ifndef RICE_SEQ_WATCHDOG_EN
                if (wait_cnt == HOLD) begin
                    iOptDone = 1'b1;
                    iOptBest = cur_best;
                    par_q.push_back('{cur_param, 8'(exp_part)});
                end
`endif
            end
        end

        // Downstream: optional stall on partition 1, otherwise always ready.
        iParamReady = 1'b1;
        if (oParamValid && exp_part == 1 && stall_left > 0) begin
            iParamReady = 1'b0;
            stall_left--;
            if (par_q.size() != 0) begin
                check("stall_param_stable", oParam, par_q[0].param);
                check("stall_index_stable", oPartIndex, par_q[0].idx);
            end
            check("stall_ready_low", oReady, 32'd0);
        end
        if (oParamValid && iParamReady) begin
            if (par_q.size() == 0) begin
                check("param_spurious", 32'd1, 32'd0);
            end else begin
                e = par_q.pop_front();
                check("param", oParam, e.param);
                check("part_index", oPartIndex, e.idx);
                param_cnt++;
                if (e.idx == 8'(NPART - 1)) bd_pending = 1'b1;
            end
        end

        // Residual stream and start control.
        iStart = 1'b0;
        if (start_req) begin
            iStart     = 1'b1;
            iPredOrder = cur_pred;
            start_req  = 1'b0;
        end else if (restart_pending && oReady && exp_part == 2) begin
            iStart          = 1'b1;
            iPredOrder      = 6'd0;
            restart_pending = 1'b0;
        end
        iValid    = cur_gapped ? ~iValid : 1'b1;
        iResidual = 16'($urandom);
        if (oReady && iValid) begin
            samp_q.push_back(iResidual);
            samp_pushed++;
        end
    endtask

    task automatic clear_tracking();
        samp_q.delete();
        par_q.delete();
        feeding     = 1'b0;
        waiting     = 1'b0;
        bd_pending  = 1'b0;
        exp_part    = -1;
        part_cnt    = 0;
        reset_cnt   = 0;
        param_cnt   = 0;
        err_cnt     = 0;
        done_cnt    = 0;
        wait_cnt    = 0;
        wait_total  = 0;
        samp_pushed = 0;
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int n;
        clear_tracking();
        cur_pred        = v.pred;
        cur_best        = v.best;
        cur_param       = v.exp_param;
        cur_gapped      = v.gapped;
        stall_left      = v.stall;
        restart_pending = v.restart;
        withhold_part   = v.withhold;
        len0            = v.exp_len0;
        start_req       = 1'b1;
        n = 0;
        while (n < BUDGET && done_cnt == 0 && !(v.exp_done == 0 && n >= 8)) begin
            step_cycle();
            n++;
        end
        if (v.exp_done != 0 && done_cnt == 0) check($sformatf("%s:timeout", tag), n, 32'd0);
        repeat (3) step_cycle();
        check($sformatf("%s:opt_resets", tag), reset_cnt, v.exp_resets);
        check($sformatf("%s:params", tag), param_cnt, v.exp_params);
        check($sformatf("%s:errors", tag), err_cnt, v.exp_errors);
        check($sformatf("%s:block_done", tag), done_cnt, v.exp_done);
        check($sformatf("%s:param_q_left", tag), par_q.size(), 32'd0);
        check($sformatf("%s:idle_ready", tag), oReady, 32'd0);
        check($sformatf("%s:idle_valid", tag), oParamValid, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s:oReady", tag), oReady, 32'd0);
        check($sformatf("%s:oOptReset", tag), oOptReset, 32'd0);
        check($sformatf("%s:oOptValid", tag), oOptValid, 32'd0);
        check($sformatf("%s:oOptResidual", tag), oOptResidual, 32'd0);
        check($sformatf("%s:oParam", tag), oParam, 32'd0);
        check($sformatf("%s:oParamValid", tag), oParamValid, 32'd0);
        check($sformatf("%s:oPartIndex", tag), oPartIndex, 32'd0);
        check($sformatf("%s:oBlockDone", tag), oBlockDone, 32'd0);
        check($sformatf("%s:oError", tag), oError, 32'd0);
    endtask

    initial begin
        //          pred   best   gap   stall rst  hold len0 param  rsts prm err done
        vecs[0] = '{6'd1,  4'd3,  1'b0, 0,    1'b0, -1, 3,   4'd3,  4,   4,  0,  1};
        vecs[1] = '{6'd1,  4'd7,  1'b0, 5,    1'b0, -1, 3,   4'd7,  4,   4,  0,  1};
        vecs[2] = '{6'd0,  4'd0,  1'b1, 0,    1'b1, -1, 4,   4'd0,  4,   4,  0,  1};
        vecs[3] = '{6'd3,  4'd15, 1'b0, 0,    1'b0, -1, 1,   4'd14, 4,   4,  0,  1};
        vecs[4] = '{6'd2,  4'd14, 1'b1, 0,    1'b0, -1, 2,   4'd14, 4,   4,  0,  1};
        vecs[5] = '{6'd4,  4'd3,  1'b0, 0,    1'b0, -1, 0,   4'd3,  0,   0,  1,  0};
        vecs[6] = '{6'd63, 4'd3,  1'b0, 0,    1'b0, -1, 0,   4'd3,  0,   0,  1,  0};
        vecs[7] = '{6'd1,  4'd5,  1'b0, 0,    1'b0, 1,  3,   4'd5,  4,   4,  WD_ERRORS, 1};

        iReset      = 1'b0;
        iStart      = 1'b0;
        iPredOrder  = '0;
        iValid      = 1'b0;
        iResidual   = '0;
        iOptDone    = 1'b0;
        iOptBest    = '0;
        iParamReady = 1'b1;
        cur_gapped  = 1'b0;
        start_req   = 1'b0;
        restart_pending = 1'b0;
        withhold_part   = -1;
        clear_tracking();

        #2 iReset = 1'b1;
        #5 check_all_zero("reset");
        @(negedge iClock);
        iReset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_block(vecs[i], $sformatf("vec%0d", i));
        end
        check("watchdog_wait_cycles", wait_total, WD_WAIT);

        // Abort mid-FEED after two samples of partition 0, then a clean block.
        clear_tracking();
        cur_pred        = 6'd1;
        cur_gapped      = 1'b0;
        withhold_part   = -1;
        restart_pending = 1'b0;
        start_req       = 1'b1;
        for (int n = 0; n < 50 && samp_pushed < 2; n++) step_cycle();
        check("abort:samples_before_reset", samp_pushed, 32'd2);
        @(negedge iClock);
        iReset = 1'b1;
        iValid = 1'b0;
        #1 check_all_zero("abort");
        @(negedge iClock);
        iReset = 1'b0;
        run_block(vecs[0], "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rice_partition_sequencer.md
Name: rice_partition_sequencer

Overview:
- Sequences the shared Rice-parameter optimizer across the partitions of one FLAC residual block.
- Splits the incoming residual stream into 2^PARTITION_ORDER partitions and clears the optimizer before each partition.
- Forwards each partition's samples, waits for the optimizer's done pulse, then hands the chosen parameter downstream with a valid/ready handshake.
- Sits between the LPC residual generator and the residual bitstream writer.

Parameters:
- BLOCK_SIZE, 4096: samples per block; must be a power of two, max 65535.
- PARTITION_ORDER, 2: log2 of the partition count per block; BLOCK_SIZE>>PARTITION_ORDER must be >= 2.
- TIMEOUT, 64: cycles to wait for iOptDone before the watchdog fires (used only with the optional feature).

Ports:
- iClock  in  1  clock
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle pulse; begins a block; ignored unless in IDLE
- iPredOrder  in  6  predictor order, latched on iStart; first partition length = PART_SIZE - iPredOrder
- iValid  in  1  residual valid
- iResidual  in  16 signed  residual sample
- oReady  out  1  sequencer accepts iResidual this cycle
- oOptReset  out  1  optimizer clear pulse
- oOptValid  out  1  sample valid to optimizer
- oOptResidual  out  16  sample to optimizer
- iOptDone  in  1  optimizer result-ready pulse
- iOptBest  in  4  optimizer chosen parameter, 0..14
- oParam  out  4  Rice parameter for current partition
- oParamValid  out  1  oParam valid
- iParamReady  in  1  downstream accepts oParam
- oPartIndex  out  8  index of the partition being emitted
- oBlockDone  out  1  one-cycle pulse after the last partition's parameter is accepted
- oError  out  1  one-cycle pulse on illegal start or watchdog event

Behaviour:
- Reset value of every output is 0. State resets to IDLE.
- Derived values:
  - PART_SIZE = BLOCK_SIZE >> PARTITION_ORDER.
  - NPART = 1 << PARTITION_ORDER.
  - Sample counter and partition counter are 16 bits, unsigned.
- FSM states: IDLE, CLEAR, FEED, WAIT, EMIT.
- IDLE:
  - On iStart with iPredOrder < PART_SIZE: latch iPredOrder, set partition index to 0, go to CLEAR.
  - On iStart with iPredOrder >= PART_SIZE: pulse oError and stay in IDLE.
- CLEAR:
  - Drive oOptReset=1 for exactly one cycle.
  - Load the remaining-sample count: PART_SIZE - predOrder for partition 0, PART_SIZE otherwise.
  - Go to FEED.
- FEED:
  - oReady=1.
  - A transfer occurs when iValid && oReady. It drives oOptValid=1 and oOptResidual=iResidual, registered, so the optimizer sees the sample one cycle later.
  - Each transfer decrements the remaining count. The transfer that takes the count to 0 moves the FSM to WAIT, and oReady drops the following cycle.
- WAIT:
  - oReady=0.
  - On iOptDone, latch iOptBest into oParam and go to EMIT.
  - An iOptDone that arrives in any state other than WAIT is ignored.
- EMIT:
  - oParamValid=1. oParam and oPartIndex are held stable until iParamReady.
  - On accept, if this was the last partition: pulse oBlockDone the next cycle and go to IDLE.
  - Otherwise: increment the partition index and go to CLEAR.
- iParamReady may be held high continuously, giving one-cycle EMIT.
- Latency: at least 1 cycle from the last sample to WAIT; at least 1 cycle from iOptDone to oParamValid.
- An iStart pulse outside IDLE is ignored; no error is flagged.
- iReset asserted mid-block aborts immediately: all outputs go to 0 and state goes to IDLE. A partially fed optimizer is cleared by the next CLEAR.
- If iOptBest > 14 it is saturated to 14.

Optional Feature:
- Macro: RICE_SEQ_WATCHDOG_EN.
- With the macro defined:
  - A counter runs in WAIT. If TIMEOUT cycles pass without iOptDone, oParam is forced to 4'd14 (escape-safe maximum).
  - oError pulses for one cycle and the FSM goes to EMIT normally.
- Without the macro: WAIT blocks indefinitely, and no counter logic is synthesised.

Decomposition:
- Shared package holds:
  - FSM state encoding, 3-bit.
  - Constant RICE_PARAM_MAX = 14.
  - RICE_PARAM_W = 4, RESID_W = 16.
- One sub-module, rice_seq_counter: a loadable down-counter with a zero flag, reused for sample counting and for the watchdog.

Test Plan:
- Nominal block, BLOCK_SIZE=16, PARTITION_ORDER=2, iPredOrder=1, iOptBest fixed at 3, iParamReady=1:
  - Partitions 0..3 take 3,4,4,4 samples.
  - oParam=3 is emitted four times with oPartIndex 0..3, then one oBlockDone pulse.
  - oOptReset pulses exactly 4 times.
- Backpressure: iParamReady low for 5 cycles in EMIT of partition 1 -> oParamValid, oParam and oPartIndex stay stable; oReady remains 0; no sample is lost.
- Illegal start: iPredOrder=4 with PART_SIZE=4 -> oError pulses once; state stays IDLE; oOptReset never asserts.
- Reset mid-FEED after 2 samples -> all outputs 0 the next cycle. A subsequent iStart runs a full clean block: oPartIndex starts at 0 and 4 parameters are emitted.
- iValid gapped every other cycle -> the sample count per partition is unchanged and oOptValid mirrors the accepted samples delayed by 1 cycle.
- With RICE_SEQ_WATCHDOG_EN and TIMEOUT=8, iOptDone withheld -> after 8 WAIT cycles, oParam=14 and oError pulses once. Without the macro, the FSM stays in WAIT for 100+ cycles.
